// File: rtl/rgb_sequencer.sv
// rgb_sequencer: drives the three PWM levels of the RGB mixer.
// MANUAL slews each level one LSB per tick toward its encoder value; a mode
// button edge moves to ENTER, which slews to pure red (255,0,0), after which
// RUN walks a six-phase hue wheel by ramping one channel at a time.
//
// Handshake note: there is no valid/ready traffic here. mode_btn is a level
// whose rising edge (one per press) is the only request; hold and man0..2
// are sampled levels with no acknowledge.
module rgb_sequencer #(
  parameter int TICK_DIV = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       hold,
  input  logic [7:0] man0,
  input  logic [7:0] man1,
  input  logic [7:0] man2,
  output logic [7:0] level0,
  output logic [7:0] level1,
  output logic [7:0] level2,
  output logic       auto_mode,
  output logic [2:0] phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  // Element 0 is red, so pure red is (255,0,0) reading channel 0 first.
  localparam logic [2:0][7:0] ENTER_TGT = {8'd0, 8'd0, 8'd255};

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    ENTER  = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    presc;
  logic             mode_q;
  logic             tick;
  logic             btn_edge;
  logic [2:0][7:0]  lvl_q, lvl_nx;
  logic [2:0][7:0]  man_v;
  logic [2:0]       phase_nx;
  logic [1:0]       ramp_ch;
  logic             ramp_up;
  logic [7:0]       ramp_cur;
  logic [7:0]       ramp_new;

  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    if (cur < tgt)      step_toward = cur + 8'd1;
    else if (cur > tgt) step_toward = cur - 8'd1;
    else                step_toward = cur;
  endfunction

  assign tick     = (presc == PRESC_MAX);
  assign btn_edge = mode_btn & ~mode_q;
  assign man_v    = {man2, man1, man0};

  assign level0 = lvl_q[0];
  assign level1 = lvl_q[1];
  assign level2 = lvl_q[2];

  // Wheel table: which channel ramps in the current phase, and which way.
  always_comb begin
    ramp_ch = 2'd1;
    ramp_up = 1'b1;
    case (phase)
      3'd0: begin ramp_ch = 2'd1; ramp_up = 1'b1; end
      3'd1: begin ramp_ch = 2'd0; ramp_up = 1'b0; end
      3'd2: begin ramp_ch = 2'd2; ramp_up = 1'b1; end
      3'd3: begin ramp_ch = 2'd1; ramp_up = 1'b0; end
      3'd4: begin ramp_ch = 2'd0; ramp_up = 1'b1; end
      3'd5: begin ramp_ch = 2'd2; ramp_up = 1'b0; end
      default: begin ramp_ch = 2'd1; ramp_up = 1'b1; end
    endcase
    ramp_cur = lvl_q[ramp_ch];
    // Saturating step so a channel can never wrap past its endpoint.
    if (ramp_up) ramp_new = (ramp_cur == 8'd255) ? 8'd255 : ramp_cur + 8'd1;
    else         ramp_new = (ramp_cur == 8'd0)   ? 8'd0   : ramp_cur - 8'd1;
  end

  // Next-state, next-level and next-phase logic; a button edge wins over a tick.
  always_comb begin
    state_nx = state;
    lvl_nx   = lvl_q;
    phase_nx = phase;
    case (state)
      MANUAL: begin
        if (btn_edge) begin
          state_nx = ENTER;
        end else if (tick) begin
          for (int i = 0; i < 3; i++) lvl_nx[i] = step_toward(lvl_q[i], man_v[i]);
        end
      end
      ENTER: begin
        if (btn_edge) begin
          state_nx = MANUAL;
        end else if (lvl_q == ENTER_TGT) begin
          state_nx = RUN;
          phase_nx = 3'd0;
        end else if (tick) begin
          for (int i = 0; i < 3; i++) lvl_nx[i] = step_toward(lvl_q[i], ENTER_TGT[i]);
        end
      end
      RUN: begin
        if (btn_edge) begin
          state_nx = MANUAL;
          phase_nx = 3'd0;
        end else if (tick && !hold) begin
          lvl_nx[ramp_ch] = ramp_new;
          if (ramp_new == (ramp_up ? 8'd255 : 8'd0))
            phase_nx = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
        end
      end
      default: begin
        state_nx = MANUAL;
        phase_nx = 3'd0;
      end
    endcase
  end

  // State, levels, phase, prescaler and button history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MANUAL;
      lvl_q     <= '0;
      phase     <= 3'd0;
      auto_mode <= 1'b0;
      presc     <= '0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      lvl_q     <= lvl_nx;
      phase     <= phase_nx;
      auto_mode <= (state_nx != MANUAL);
      presc     <= tick ? '0 : presc + PW'(1);
      mode_q    <= mode_btn;
    end
  end

endmodule

// File: tb/tb_rgb_sequencer.sv
// Bench for rgb_sequencer at TICK_DIV=4: table-driven manual slew vectors,
// hand-written auto/hold/edge/reset sequences, then random stimulus checked
// against a cycle model built from the wheel rules.
module tb_rgb_sequencer;

  localparam int TD = 4;

  // Clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] man0 = '0, man1 = '0, man2 = '0;
  logic [7:0] level0, level1, level2;
  logic       auto_mode;
  logic [2:0] phase;

  always #5 clk = ~clk;

  rgb_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .hold(hold),
    .man0(man0), .man1(man1), .man2(man2),
    .level0(level0), .level1(level1), .level2(level2),
    .auto_mode(auto_mode), .phase(phase)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_lv(input string name, input int e0, input int e1, input int e2);
    check({name, ".l0"}, 32'(level0), 32'(e0));
    check({name, ".l1"}, 32'(level1), 32'(e1));
    check({name, ".l2"}, 32'(level2), 32'(e2));
  endtask

  // Driver tasks
  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    mode_btn = 1'b0;
    hold = 1'b0;
    clocks(2);
    reset = 1'b1;
  endtask

  function automatic int sat_sub(input int v, input int d);
    return (v > d) ? v - d : 0;
  endfunction

  // Manual slew vectors: set targets, run 'ticks' ticks, expect levels.
  typedef struct {
    logic [7:0] m0, m1, m2;
    int         ticks;
    logic [7:0] e0, e1, e2;
  } vec_t;
  vec_t vecs[9];

  // Reference model: wheel described as (channel, direction) per phase.
  localparam int M_MAN = 0, M_ENTER = 1, M_RUN = 2;
  int wheel_ch[6]  = '{1, 0, 2, 1, 0, 2};
  int wheel_dir[6] = '{1, -1, 1, -1, 1, -1};
  int m_lv[3];
  int m_mode, m_phase, m_count, m_btn_prev;
  logic [27:0] exp_q[$];

  function automatic logic [27:0] model_word();
    return {8'(m_lv[0]), 8'(m_lv[1]), 8'(m_lv[2]), (m_mode != M_MAN), 3'(m_phase)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_lv[i] = 0;
    m_mode = M_MAN; m_phase = 0; m_count = 0; m_btn_prev = 0;
  endtask

  // One clock of behaviour, using the inputs that the next edge will sample.
  task automatic model_step(input int btn, input int hld, input int t0, input int t1, input int t2);
    int tgt[3];
    int is_tick, press;
    is_tick = (m_count == TD - 1);
    m_count = (m_count + 1) % TD;
    press = btn && !m_btn_prev;
    m_btn_prev = btn;
    if (press) begin
      if (m_mode == M_MAN) m_mode = M_ENTER;
      else begin m_mode = M_MAN; m_phase = 0; end
    end else if (m_mode == M_ENTER && m_lv[0] == 255 && m_lv[1] == 0 && m_lv[2] == 0) begin
      m_mode = M_RUN; m_phase = 0;
    end else if (is_tick && m_mode != M_RUN) begin
      if (m_mode == M_MAN) begin tgt[0] = t0; tgt[1] = t1; tgt[2] = t2; end
      else begin tgt[0] = 255; tgt[1] = 0; tgt[2] = 0; end
      for (int i = 0; i < 3; i++)
        if (m_lv[i] < tgt[i]) m_lv[i]++; else if (m_lv[i] > tgt[i]) m_lv[i]--;
    end else if (is_tick && m_mode == M_RUN && !hld) begin
      int c, d;
      c = wheel_ch[m_phase];
      d = wheel_dir[m_phase];
      m_lv[c] = m_lv[c] + d;
      if (m_lv[c] > 255) m_lv[c] = 255;
      if (m_lv[c] < 0) m_lv[c] = 0;
      if (m_lv[c] == ((d > 0) ? 255 : 0)) m_phase = (m_phase + 1) % 6;
    end
  endtask

  initial begin
    int l0, l1, l2, found;
    vecs[0] = '{10, 0, 3, 3, 3, 0, 3};
    vecs[1] = '{10, 0, 3, 7, 10, 0, 3};
    vecs[2] = '{10, 0, 3, 5, 10, 0, 3};
    vecs[3] = '{7, 0, 3, 1, 9, 0, 3};
    vecs[4] = '{7, 0, 3, 1, 8, 0, 3};
    vecs[5] = '{7, 0, 3, 1, 7, 0, 3};
    vecs[6] = '{7, 0, 3, 4, 7, 0, 3};
    vecs[7] = '{0, 5, 0, 10, 0, 5, 0};
    vecs[8] = '{0, 0, 0, 5, 0, 0, 0};

    // Reset state, held across a few edges
    clocks(2);
    check_lv("rst", 0, 0, 0);
    check("rst.auto", 32'(auto_mode), 0);
    check("rst.phase", 32'(phase), 0);
    reset = 1'b1;

    // Manual slew table; every wait is a whole number of ticks
    for (int v = 0; v < 9; v++) begin
      man0 = vecs[v].m0; man1 = vecs[v].m1; man2 = vecs[v].m2;
      clocks(TD * vecs[v].ticks);
      check_lv($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2);
      check($sformatf("vec%0d.auto", v), 32'(auto_mode), 0);
    end

    // Auto entry from (0,0,0): edge enters ENTER, red ramps 255 ticks
    mode_btn = 1'b1;
    clocks(1);
    check("enter.auto", 32'(auto_mode), 1);
    clocks(3 + TD * 253);
    check_lv("enter.254", 254, 0, 0);
    clocks(TD);
    check_lv("enter.255", 255, 0, 0);
    mode_btn = 1'b0;
    clocks(TD * 254);
    check_lv("ph0.254", 255, 254, 0);
    check("ph0.phase", 32'(phase), 0);
    clocks(TD);
    check_lv("ph0.end", 255, 255, 0);
    check("ph1.phase", 32'(phase), 1);

    // Rest of the wheel brings it back to red, phase 0
    clocks(TD * 5 * 255);
    check_lv("wheel", 255, 0, 0);
    check("wheel.phase", 32'(phase), 0);
    check("wheel.auto", 32'(auto_mode), 1);

    // Into phase 2, then hold for 100 ticks
    clocks(TD * (255 * 2 + 100));
    check_lv("ph2", 0, 255, 100);
    check("ph2.phase", 32'(phase), 2);
    hold = 1'b1;
    clocks(TD * 100);
    check_lv("hold", 0, 255, 100);
    check("hold.phase", 32'(phase), 2);
    hold = 1'b0;
    clocks(TD * 50);
    check_lv("resume", 0, 255, 150);

    // Edge landing on a tick cycle: levels hold, state goes to MANUAL
    clocks(TD - 1);
    mode_btn = 1'b1;
    clocks(1);
    check_lv("edge_tick", 0, 255, 150);
    check("edge_tick.auto", 32'(auto_mode), 0);
    check("edge_tick.phase", 32'(phase), 0);
    // Button held 50 cycles: still MANUAL, 12 ticks of slew toward (0,0,0)
    clocks(49);
    check("held.auto", 32'(auto_mode), 0);
    check_lv("held", 0, 243, 138);

    // Edge during ENTER returns to MANUAL and slews from the current levels
    mode_btn = 1'b0;
    clocks(1);
    mode_btn = 1'b1;
    clocks(1);
    check("enter2.auto", 32'(auto_mode), 1);
    clocks(40);
    mode_btn = 1'b0;
    clocks(2);
    l0 = level0; l1 = level1; l2 = level2;
    mode_btn = 1'b1;
    clocks(1);
    check("abort.auto", 32'(auto_mode), 0);
    check_lv("abort", l0, l1, l2);
    clocks(2 * TD);
    check_lv("abort.slew", sat_sub(l0, 2), sat_sub(l1, 2), sat_sub(l2, 2));

    // Reset in the middle of RUN, asynchronous to the clock
    mode_btn = 1'b0;
    clocks(1);
    mode_btn = 1'b1;
    found = 0;
    for (int i = 0; i < 3000; i++) begin
      clocks(1);
      if (phase == 3'd1) begin found = 1; break; end
    end
    check("run_wait", 32'(found), 1);
    clocks(37);
    #1 reset = 1'b0;
    #1;
    check_lv("async_rst", 0, 0, 0);
    check("async_rst.auto", 32'(auto_mode), 0);
    check("async_rst.phase", 32'(phase), 0);
    mode_btn = 1'b0;
    clocks(3);
    reset = 1'b1;
    clocks(10);
    check("post_rst.auto", 32'(auto_mode), 0);
    check_lv("post_rst", 0, 0, 0);

    // Random stimulus against the model, through the expected queue
    do_reset();
    model_reset();
    exp_q.push_back(model_word());
    begin
      int seg_left = 0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
        logic [27:0] act, exp;
        if (cyc != 0) @(negedge clk);
        act = {level0, level1, level2, auto_mode, phase};
        if (exp_q.size() == 0) check("rand.queue", 0, 1);
        else begin
          exp = exp_q.pop_front();
          check($sformatf("rand%0d", cyc), 32'(act), 32'(exp));
        end
        if (seg_left == 0) begin
          seg_left = $urandom_range(10, 2500);
          if ($urandom_range(0, 9) < 7) mode_btn = ~mode_btn;
        end
        seg_left--;
        if ($urandom_range(0, 99) < 3) hold = ~hold;
        if ($urandom_range(0, 199) == 0) man0 = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 199) == 0) man1 = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 199) == 0) man2 = 8'($urandom_range(0, 255));
        model_step(int'(mode_btn), int'(hold), int'(man0), int'(man1), int'(man2));
        exp_q.push_back(model_word());
      end
    end

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
